// File: rtl/axi_pkg.sv
// Shared AXI encodings and helpers for the AXI4 / AXI4-lite converters.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StResp
    } wr_state_e;

    // Beats wider than the bus are treated as full-width beats.
    function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
        return (size > max_size) ? max_size : size;
    endfunction

endpackage

// File: rtl/axi_addr_next.sv
// Combinational next-beat address for AXI4 FIXED / INCR / WRAP bursts.
// WRAP is honoured only when AXI_AXIL_ADAPTER_WR_WRAP_EN is defined; otherwise it behaves as INCR.
module axi_addr_next
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] incr_addr;

    assign step      = ADDR_WIDTH'(1) << size;
    assign aligned   = addr & ~(step - ADDR_WIDTH'(1));
    assign incr_addr = aligned + step;

`ifdef AXI_AXIL_ADAPTER_WR_WRAP_EN
    logic                  wrap_legal;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    assign wrap_legal = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    // Bits below log2((len+1) << size) wrap inside the boundary-aligned window.
    assign wrap_mask  = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    always_comb begin
        next_addr = incr_addr;
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end
`ifdef AXI_AXIL_ADAPTER_WR_WRAP_EN
        else if ((burst == BURST_WRAP) && wrap_legal) begin
            next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        end
`endif
    end

endmodule

// File: rtl/axi_axil_adapter_wr.sv
// AXI4 write burst to sequential AXI4-lite single writes, one aggregated B per burst.
// Define AXI_AXIL_ADAPTER_WR_WRAP_EN to support WRAP; otherwise WRAP is drained and answered SLVERR.
module axi_axil_adapter_wr
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready
);

    localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_WIDTH));

    wr_state_e             state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [1:0]            resp_acc_q, resp_acc_d;
    logic                  drop_q, drop_d;

    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] m_awaddr_q, m_awaddr_d;
    logic [2:0]            m_awprot_q, m_awprot_d;
    logic                  m_awvalid_q, m_awvalid_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [STRB_WIDTH-1:0] m_wstrb_q, m_wstrb_d;
    logic                  m_wvalid_q, m_wvalid_d;
    logic                  m_bready_q, m_bready_d;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [1:0]            resp_next;
    logic                  drop_new;
    logic                  unused_wlast;

    // Beat count comes from awlen alone.
    assign unused_wlast = s_axi_wlast;

`ifdef AXI_AXIL_ADAPTER_WR_WRAP_EN
    assign drop_new = 1'b0;
`else
    assign drop_new = (s_axi_awburst == BURST_WRAP);
`endif

    axi_addr_next #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_next (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beat_cnt_d  = beat_cnt_q;
        resp_acc_d  = resp_acc_q;
        drop_d      = drop_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        m_awaddr_d  = m_awaddr_q;
        m_awprot_d  = m_awprot_q;
        m_wdata_d   = m_wdata_q;
        m_wstrb_d   = m_wstrb_q;
        m_bready_d  = m_bready_q;
        resp_next   = resp_acc_q;
        m_awvalid_d = m_awvalid_q && !m_axil_awready;
        m_wvalid_d  = m_wvalid_q && !m_axil_wready;
        bvalid_d    = bvalid_q && !s_axi_bready;

        unique case (state_q)
            StIdle: begin
                // Hold off a new burst while the previous B is still unaccepted.
                awready_d = !m_awvalid_d && !bvalid_d;
                if (s_axi_awvalid && awready_q) begin
                    awready_d  = 1'b0;
                    id_d       = s_axi_awid;
                    addr_d     = s_axi_awaddr;
                    len_d      = s_axi_awlen;
                    size_d     = clamp_size(s_axi_awsize, SIZE_MAX);
                    burst_d    = s_axi_awburst;
                    beat_cnt_d = s_axi_awlen;
                    drop_d     = drop_new;
                    resp_acc_d = drop_new ? RESP_SLVERR : RESP_OKAY;
                    m_awprot_d = s_axi_awprot;
                    if (!drop_new) begin
                        m_awaddr_d  = s_axi_awaddr;
                        m_awvalid_d = 1'b1;
                    end
                    wready_d = !m_wvalid_d;
                    state_d  = StData;
                end
            end
            StData: begin
                if (s_axi_wvalid && wready_q) begin
                    wready_d = 1'b0;
                    if (!drop_q) begin
                        m_wdata_d  = s_axi_wdata;
                        m_wstrb_d  = s_axi_wstrb;
                        m_wvalid_d = 1'b1;
                        m_bready_d = !bvalid_d;
                    end
                    state_d = StResp;
                end else begin
                    wready_d = !m_wvalid_d;
                end
            end
            StResp: begin
                // Dropped bursts complete each beat without touching the lite side.
                if (drop_q || (m_axil_bvalid && m_bready_q)) begin
                    m_bready_d = 1'b0;
                    if (!drop_q && (resp_acc_q == RESP_OKAY)) begin
                        resp_next = m_axil_bresp;
                    end
                    resp_acc_d = resp_next;
                    if (beat_cnt_q == 8'd0) begin
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = resp_next;
                        state_d  = StIdle;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                        addr_d     = next_addr;
                        if (!drop_q) begin
                            m_awaddr_d  = next_addr;
                            m_awvalid_d = 1'b1;
                        end
                        wready_d = !m_wvalid_d;
                        state_d  = StData;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_cnt_q  <= '0;
            resp_acc_q  <= RESP_OKAY;
            drop_q      <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= '0;
            m_awaddr_q  <= '0;
            m_awprot_q  <= '0;
            m_awvalid_q <= 1'b0;
            m_wdata_q   <= '0;
            m_wstrb_q   <= '0;
            m_wvalid_q  <= 1'b0;
            m_bready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_cnt_q  <= beat_cnt_d;
            resp_acc_q  <= resp_acc_d;
            drop_q      <= drop_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            m_awaddr_q  <= m_awaddr_d;
            m_awprot_q  <= m_awprot_d;
            m_awvalid_q <= m_awvalid_d;
            m_wdata_q   <= m_wdata_d;
            m_wstrb_q   <= m_wstrb_d;
            m_wvalid_q  <= m_wvalid_d;
            m_bready_q  <= m_bready_d;
        end
    end

    assign s_axi_awready  = awready_q;
    assign s_axi_wready   = wready_q;
    assign s_axi_bvalid   = bvalid_q;
    assign s_axi_bid      = bid_q;
    assign s_axi_bresp    = bresp_q;
    assign m_axil_awaddr  = m_awaddr_q;
    assign m_axil_awprot  = m_awprot_q;
    assign m_axil_awvalid = m_awvalid_q;
    assign m_axil_wdata   = m_wdata_q;
    assign m_axil_wstrb   = m_wstrb_q;
    assign m_axil_wvalid  = m_wvalid_q;
    assign m_axil_bready  = m_bready_q;

endmodule
